// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the DSO capture sequencer.
package capture_pkg;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;
  localparam int DW = 4;
  localparam int PW = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;
endpackage

// File: rtl/capture_ctrl_tick.sv
// Decimation prescaler: one tick every 2**decimator clocks while enabled.
module sample_tick_gen
  import capture_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] decimator,
  output logic          tick
);
  logic [PW-1:0] cnt;
  logic [PW-1:0] term;

  assign term = (PW'(1) << decimator) - PW'(1);
  assign tick = en && (cnt == term);

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: pre-trigger fill, arm, post-trigger count, done.
// Optional CAPTURE_ABORT_EN adds an abort input that returns to IDLE.
module capture_ctrl
  import capture_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] trig_pos,
  input  logic [DW-1:0] decimator,
  input  logic          triggered,
  input  logic          capture_ack,
`ifdef CAPTURE_ABORT_EN
  input  logic          abort,
`endif
  output logic          trig_en,
  output logic          armed,
  output logic          set_capture_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trig_addr,
  output logic          capture_done,
  output logic          busy
);
  cap_state_t    state;
  logic [AW-1:0] tp_q;
  logic [DW-1:0] dec_q;
  logic [AW:0]   pre_cnt;
  logic [AW:0]   pre_nxt;
  logic [AW:0]   pre_quota;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] post_nxt;
  logic          tick;
  logic          abort_hit;

  sample_tick_gen u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .decimator (dec_q),
    .tick      (tick)
  );

`ifdef CAPTURE_ABORT_EN
  assign abort_hit = abort && (state inside {FILL, ARMED, POST});
`else
  assign abort_hit = 1'b0;
`endif

  assign pre_quota = (AW+1)'(DEPTH) - {1'b0, tp_q};
  assign pre_nxt   = pre_cnt + 1'b1;
  assign post_nxt  = post_cnt + 1'b1;

  // trig_pos of 0 means POST holds no samples
  always_comb begin
    we = 1'b0;
    unique case (1'b1)
      (state == FILL):  we = tick;
      (state == ARMED): we = tick;
      (state == POST):  we = tick && (tp_q != '0);
      default:          we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      tp_q             <= '0;
      dec_q            <= '0;
      pre_cnt          <= '0;
      post_cnt         <= '0;
      waddr            <= '0;
      trig_addr        <= '0;
      trig_en          <= 1'b0;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      capture_done     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      if (we) waddr <= waddr + 1'b1;
      if (abort_hit) begin
        state            <= IDLE;
        trig_en          <= 1'b0;
        armed            <= 1'b0;
        busy             <= 1'b0;
        set_capture_done <= 1'b1;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state   <= FILL;
            tp_q    <= trig_pos;
            dec_q   <= decimator;
            pre_cnt <= '0;
            busy    <= 1'b1;
            trig_en <= 1'b1;
          end
          FILL: if (tick) begin
            pre_cnt <= pre_nxt;
            if (pre_nxt == pre_quota) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
          ARMED: if (triggered) begin
            state     <= POST;
            trig_addr <= waddr;
            post_cnt  <= '0;
            trig_en   <= 1'b0;
            armed     <= 1'b0;
          end
          POST: begin
            if (tp_q == '0 || (tick && post_nxt == tp_q)) begin
              state            <= DONE;
              set_capture_done <= 1'b1;
              capture_done     <= 1'b1;
            end else if (tick) begin
              post_cnt <= post_nxt;
            end
          end
          DONE: if (capture_ack) begin
            state        <= IDLE;
            capture_done <= 1'b0;
            busy         <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: event-time model per acquisition, checked each cycle.
`timescale 1ns/1ps
module tb_capture_ctrl;
  import capture_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          triggered = 1'b0;
  logic          capture_ack = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic [DW-1:0] decimator = '0;
  logic          trig_en, armed, set_capture_done, we, capture_done, busy;
  logic [AW-1:0] waddr, trig_addr;
`ifdef CAPTURE_ABORT_EN
  logic          abort = 1'b0;
`endif

  always #5 clk = ~clk;

  capture_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .triggered        (triggered),
    .capture_ack      (capture_ack),
`ifdef CAPTURE_ABORT_EN
    .abort            (abort),
`endif
    .trig_en          (trig_en),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .we               (we),
    .waddr            (waddr),
    .trig_addr        (trig_addr),
    .capture_done     (capture_done),
    .busy             (busy)
  );

  localparam int BIG = 1 << 20;

  int checks = 0;
  int errors = 0;
  int k = 0;
  bit active = 1'b0;
  // event times, relative to the start cycle (k = 0)
  int P, t_armed, ka, wend, kd, kfin, krst, kab;
  int wcnt, base = 0, ta_prev = 0, ta_new = 0;
  int first_armed, post_we, scd_cnt, scd_k;
  bit cd_seen;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0d want %0d", name, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e_busy, e_ten, e_arm, e_we, e_scd, e_cd;
    int e_wa, e_ta;
    if (active) begin
      if (krst > 0 && k > krst) begin
        {e_busy, e_ten, e_arm, e_we, e_scd, e_cd} = '0;
        e_wa = 0;
        e_ta = 0;
      end else begin
        e_busy = k >= 1 && k < kfin;
        e_ten  = e_busy && k <= ka;
        e_arm  = e_busy && k > t_armed && k <= ka;
        e_we   = e_busy && (k % P == 0) && k <= wend;
        e_scd  = (k == kd) || (kab > 0 && k == kab + 1);
        e_cd   = k >= kd && k < kfin;
        e_wa   = (base + wcnt) % DEPTH;
        if (k == ka) ta_new = e_wa;
        e_ta = (k > ka && (kab == 0 || ka < kab)) ? ta_new : ta_prev;
      end
      chk("busy", busy, e_busy);
      chk("trig_en", trig_en, e_ten);
      chk("armed", armed, e_arm);
      chk("we", we, e_we);
      chk("set_capture_done", set_capture_done, e_scd);
      chk("capture_done", capture_done, e_cd);
      chk("waddr", waddr, e_wa);
      chk("trig_addr", trig_addr, e_ta);
      if (e_we) wcnt++;
      if (armed && first_armed < 0) first_armed = k;
      if (we && k > ka) post_we++;
      if (set_capture_done) begin
        scd_cnt++;
        scd_k = k;
      end
      if (capture_done) cd_seen = 1'b1;
    end
  end

  task automatic run_acq(input int dec, input int tpv, input int kt,
                         input int kk, input int ks, input int kack,
                         input int rst_at, input int ab_at);
    int kend;
    P       = 1 << dec;
    t_armed = (DEPTH - tpv) * P;
    ka      = (kt > t_armed) ? kt : t_armed + 1;
    if (tpv == 0) begin
      wend = ka;
      kd   = ka + 2;
    end else begin
      wend = ((ka / P) + 1) * P + (tpv - 1) * P;
      kd   = wend + 1;
    end
    kfin = ((kk > kd) ? kk : kd) + 1;
    krst = rst_at;
    kab  = ab_at;
    if (ab_at > 0) begin
      kfin = ab_at + 1;
      kd   = 1 << 30;
    end
    kend = (rst_at > 0) ? rst_at + 3 : kfin + 2;
    wcnt = 0;
    first_armed = -1;
    post_we = 0;
    scd_cnt = 0;
    scd_k = -1;
    cd_seen = 1'b0;
    @(posedge clk); #1;
    k = 0;
    start = 1'b1;
    trig_pos = AW'(tpv);
    decimator = DW'(dec);
    active = 1'b1;
    while (k < kend) begin
      @(posedge clk); #1;
      k++;
      start = (k == ks);
      trig_pos = AW'($urandom);
      decimator = DW'($urandom);
      triggered = k >= kt && k < kd && !(rst_at > 0 && k > rst_at)
                  && !(ab_at > 0 && k > ab_at);
      capture_ack = (k == kack) || (k >= kk && k < kfin);
      rst_n = (k != rst_at);
`ifdef CAPTURE_ABORT_EN
      abort = (k == ab_at);
`endif
    end
    @(negedge clk);
    active = 1'b0;
    start = 1'b0;
    triggered = 1'b0;
    capture_ack = 1'b0;
    if (rst_at > 0) begin
      base = 0;
      ta_prev = 0;
    end else begin
      base = (base + wcnt) % DEPTH;
      if (ab_at == 0 || ka < ab_at) ta_prev = ta_new;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst trig_en", trig_en, 0);
    chk("rst armed", armed, 0);
    chk("rst scd", set_capture_done, 0);
    chk("rst waddr", waddr, 0);
    chk("rst trig_addr", trig_addr, 0);
    chk("rst capture_done", capture_done, 0);
    rst_n = 1'b1;

    // dec 0, trig_pos 100; ack and a stray start on the pulse cycle
    run_acq(0, 100, 433, 534, 534, 0, 0, 0);
    chk("s1 armed_k", first_armed, 413);
    chk("s1 post_we", post_we, 100);
    chk("s1 scd_cnt", scd_cnt, 1);
    chk("s1 scd_k", scd_k, 534);
    chk("s1 trig_addr", trig_addr, 432);

    // dec 2, trig_pos 256; stray start and ack during FILL
    run_acq(2, 256, 1100, 2130, 10, 20, 0, 0);
    chk("s2 armed_k", first_armed, 1025);
    chk("s2 post_we", post_we, 256);

    // trig_pos 0, trigger held from start; stray start in DONE
    run_acq(0, 0, 1, 518, 516, 0, 0, 0);
    chk("s3 armed_k", first_armed, 513);
    chk("s3 scd_k", scd_k, 515);
    chk("s3 post_we", post_we, 0);

    // reset in the middle of POST
    run_acq(0, 50, 470, BIG, 0, 0, 490, 0);
    chk("s4 waddr", waddr, 0);
    chk("s4 busy", busy, 0);

    // full run after reset; waddr wraps during a long ARMED wait
    run_acq(0, 500, 600, 1101, 0, 0, 0, 0);
    chk("s5 trig_addr", trig_addr, 87);
    chk("s5 scd_k", scd_k, 1101);

`ifdef CAPTURE_ABORT_EN
    run_acq(1, 10, BIG, BIG, 0, 0, 0, 1010);
    chk("ab1 scd_cnt", scd_cnt, 1);
    chk("ab1 cd_seen", cd_seen, 0);
    chk("ab1 busy", busy, 0);
    run_acq(0, 300, 220, BIG, 0, 0, 0, 220);
    chk("ab2 scd_k", scd_k, 221);
    chk("ab2 cd_seen", cd_seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences one DSO acquisition: paces sample writes into the 512-entry capture RAM and counts pre-trigger samples.
- Drives `armed` and `trig_en` into the trigger block and waits for `triggered`.
- Counts post-trigger samples, then pulses `set_capture_done`, which clears the trigger SR-flop and flags the buffer for host readout.
- Sits between the host command interface, the trigger block and the capture RAM write port.

Parameters:
- DEPTH, 512, capture RAM entries.
- AW, 9, RAM address width; DEPTH = 2**AW.
- DW, 4, width of the decimation select.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; begins an acquisition; honoured in IDLE only
- trig_pos  in  AW  number of samples kept after the trigger (0..511)
- decimator  in  DW  sample every 2**decimator clocks
- triggered  in  1  level from the trigger block
- capture_ack  in  1  host finished reading; releases DONE
- trig_en  out  1  enables trigger logic
- armed  out  1  pre-trigger quota stored
- set_capture_done  out  1  one-cycle pulse that clears the trigger flop
- we  out  1  RAM write strobe
- waddr  out  AW  RAM write address
- trig_addr  out  AW  `waddr` value of the first post-trigger sample
- capture_done  out  1  level; buffer valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (`rst_n` low at a clk edge, any state, mid-capture included) forces:
  - state = IDLE
  - all outputs 0; `waddr` = 0; `trig_addr` = 0
  - counters and prescaler cleared
- `tick`: the prescaler counts 0..(2**decimator − 1) while `busy` and is cleared in IDLE. `tick` is high when the prescaler equals its terminal value; decimator = 0 gives `tick` every cycle.
  - `we` = `tick` in FILL, ARMED and POST.
  - `waddr` advances by 1 on the cycle after each write, wrapping 511 → 0 (circular buffer).
- Latch `trig_pos` and `decimator` on the `start` cycle. Changes to these inputs later in the acquisition have no effect.
- Pre-trigger quota: PRE = DEPTH − trig_pos_latched, range 1..512. It uses an AW+1-bit counter `pre_cnt`.
- IDLE:
  - `start` → FILL; `pre_cnt` = 0; `waddr` keeps its previous value.
- FILL:
  - `trig_en` = 1, `armed` = 0.
  - Each `tick` increments `pre_cnt`.
  - When a `tick` makes `pre_cnt` == PRE → ARMED. `armed` rises on the next cycle.
- ARMED:
  - `trig_en` = 1, `armed` = 1. Writes continue and overwrite the oldest data.
  - `triggered` high → POST. On the same edge, capture `trig_addr` = the address of the next write.
  - `post_cnt` = 0.
  - `triggered` already high on ARMED entry is accepted on the first ARMED cycle.
- POST:
  - `trig_en` = 0, `armed` = 0.
  - Each `tick` increments `post_cnt`. When a `tick` makes `post_cnt` == trig_pos_latched → DONE.
  - trig_pos = 0: POST lasts exactly one cycle with no writes, then DONE.
- DONE:
  - `set_capture_done` = 1 for exactly the first DONE cycle.
  - `capture_done` = 1 until `capture_ack`; then → IDLE with `capture_done` = 0 on the next cycle.
  - `capture_ack` in the same cycle as the pulse is honoured.
- `start` outside IDLE and `capture_ack` outside DONE are ignored.
- Total samples written from entry to FILL until DONE = PRE + (samples during ARMED) + trig_pos. The last 512 samples are valid.

Optional Feature:
- Macro: CAPTURE_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in FILL, ARMED or POST → IDLE on the next edge.
  - On that edge: `set_capture_done` pulses for one cycle so the trigger flop clears; `capture_done` stays 0; `trig_en`/`armed` drop.
  - `abort` has priority over `tick` and `triggered` in the same cycle; it is ignored in IDLE and DONE.
- Undefined: no `abort` port; an acquisition can only end through DONE or reset.

Decomposition:
- Package `capture_pkg`:
  - DEPTH and AW constants.
  - State enum `cap_state_t` {IDLE, FILL, ARMED, POST, DONE}.
- One sub-module: `sample_tick_gen`, the decimation prescaler.
  - Inputs: clk, rst_n, en, decimator.
  - Output: `tick`.
- The FSM and counters stay in `capture_ctrl`.

Test Plan:
- decimator = 0, trig_pos = 100, start:
  - `armed` rises 413 cycles after start (412 ticks in FILL + 1).
  - Assert `triggered` 20 cycles later → exactly 100 `we` pulses, then a single `set_capture_done` pulse.
  - `trig_addr` = 432 mod 512.
- decimator = 2, trig_pos = 256 → `we` every 4th clock; `armed` after 256 ticks (1024 clocks).
- trig_pos = 0 and `triggered` held high from start:
  - ARMED entered after 512 writes; POST lasts one cycle; `set_capture_done` on the next cycle; zero post writes.
- Reset mid-POST:
  - Next cycle all outputs 0 and `waddr` = 0.
  - A subsequent `start` runs a full acquisition normally.
- `start` pulses during FILL and DONE are ignored.
- `capture_ack` on the `set_capture_done` cycle → IDLE one cycle later.
- `waddr` wraps 511 → 0 during a long ARMED wait.
- With CAPTURE_ABORT_EN, `abort` in ARMED:
  - One `set_capture_done` pulse, `capture_done` stays 0, IDLE next cycle.
  - `abort` in the same cycle as `triggered` still goes to IDLE.
